// File: rtl/test_result_monitor_if.sv
// Connection bundle between a core and test_result_monitor: core-side observation
// inputs plus the monitor's result flags and cycle count.
interface test_result_monitor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  gp_i;
    logic             mem_we_i;
    logic [XLEN-1:0]  mem_addr_i;
    logic [XLEN-1:0]  mem_wdata_i;

    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic             stalled;
    logic [XLEN-2:0]  test_num;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, pc_i, gp_i, mem_we_i, mem_addr_i, mem_wdata_i,
        input  busy, done, pass, fail, timeout, stalled, test_num, cycles
    );

    modport slave (
        input  start, pc_i, gp_i, mem_we_i, mem_addr_i, mem_wdata_i,
        output busy, done, pass, fail, timeout, stalled, test_num, cycles
    );
endinterface

// File: rtl/test_result_monitor.sv
// riscv-tests pass/fail detector (PC-match + gp, or tohost store) with a RUN-cycle watchdog.
// Define TEST_MONITOR_STALL_EN to add same-PC hang detection (STALL_LIMIT consecutive cycles).
module test_result_monitor #(
    parameter int              XLEN        = 32,
    parameter int              MODE        = 0,
    parameter logic [XLEN-1:0] PASS_PC     = 32'h44,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 32'h1000,
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = 16,
    parameter int              STALL_LIMIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    test_result_monitor_if.slave mon
);
    localparam logic [XLEN-1:0]  ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    // An illegal parameter set can never leave IDLE rather than misreport a result.
    localparam bit CFG_OK = (TIMEOUT >= 1) && (STALL_LIMIT >= 1) && ($clog2(TIMEOUT + 1) <= CNT_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cycles_r, cycles_s;
    logic             busy_r, busy_s, done_r, done_s;
    logic             pass_r, pass_s, fail_r, fail_s;
    logic             timeout_r, timeout_s, stalled_r, stalled_s;
    logic [XLEN-2:0]  test_num_r, test_num_s;

    logic             event_s, event_pass_s, stall_hit_s;
    logic [XLEN-1:0]  event_val_s;

    // Completion event decode and the value that carries the test verdict.
    always_comb begin
        if (MODE == 0) begin
            event_val_s = mon.gp_i;
            event_s     = (mon.pc_i == PASS_PC);
        end else begin
            event_val_s = mon.mem_wdata_i;
            event_s     = mon.mem_we_i && (mon.mem_addr_i == TOHOST_ADDR) && mon.mem_wdata_i[0];
        end
        event_pass_s = (event_val_s == ONE_X);
    end

`ifdef TEST_MONITOR_STALL_EN
    localparam int            SW         = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

    logic [SW-1:0]   stall_cnt_r;
    logic [XLEN-1:0] pc_prev_r;
    logic            pc_same_s;

    assign pc_same_s   = (mon.pc_i == pc_prev_r);
    assign stall_hit_s = (state_r == S_RUN) && pc_same_s && (stall_cnt_r == STALL_LAST);

    // Count consecutive repeated-PC cycles; the count is zero whenever RUN is (re)entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= {SW{1'b0}};
            pc_prev_r   <= {XLEN{1'b0}};
        end else begin
            pc_prev_r <= mon.pc_i;
            if ((state_r == S_RUN) && pc_same_s) begin
                stall_cnt_r <= stall_cnt_r + {{(SW-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= {SW{1'b0}};
            end
        end
    end
`else
    assign stall_hit_s = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= S_IDLE;
            cycles_r   <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            fail_r     <= 1'b0;
            timeout_r  <= 1'b0;
            stalled_r  <= 1'b0;
            test_num_r <= {(XLEN-1){1'b0}};
        end else begin
            state_r    <= state_s;
            cycles_r   <= cycles_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            fail_r     <= fail_s;
            timeout_r  <= timeout_s;
            stalled_r  <= stalled_s;
            test_num_r <= test_num_s;
        end
    end

    // Next state: completion beats stall, stall beats timeout; start only acts outside RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_RUN: begin
                if (event_s) begin
                    state_s = event_pass_s ? S_PASS : S_FAIL;
                end else if (stall_hit_s) begin
                    state_s = S_FAIL;
                end else if (cycles_r == TMO_LAST) begin
                    state_s = S_TMO;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_IDLE, S_PASS, S_FAIL, S_TMO: begin
                if (mon.start && CFG_OK) begin
                    state_s = S_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Next values of the result registers, derived from the current and next state.
    always_comb begin
        cycles_s   = cycles_r;
        pass_s     = pass_r;
        fail_s     = fail_r;
        timeout_s  = timeout_r;
        stalled_s  = stalled_r;
        test_num_s = test_num_r;
        if (state_r == S_RUN) begin
            cycles_s = (cycles_r == CNT_MAX) ? cycles_r : cycles_r + CNT_ONE;
            case (state_s)
                S_PASS: pass_s = 1'b1;
                S_FAIL: begin
                    fail_s     = 1'b1;
                    stalled_s  = ~event_s;
                    test_num_s = event_s ? event_val_s[XLEN-1:1] : {(XLEN-1){1'b0}};
                end
                S_TMO:   timeout_s = 1'b1;
                default: cycles_s  = cycles_s;
            endcase
        end else if (state_s == S_RUN) begin
            cycles_s   = {CNT_W{1'b0}};
            pass_s     = 1'b0;
            fail_s     = 1'b0;
            timeout_s  = 1'b0;
            stalled_s  = 1'b0;
            test_num_s = {(XLEN-1){1'b0}};
        end else begin
            cycles_s = cycles_r;
        end
        busy_s = (state_s == S_RUN);
        done_s = (state_s == S_PASS) || (state_s == S_FAIL) || (state_s == S_TMO);
    end

    assign mon.busy     = busy_r;
    assign mon.done     = done_r;
    assign mon.pass     = pass_r;
    assign mon.fail     = fail_r;
    assign mon.timeout  = timeout_r;
    assign mon.stalled  = stalled_r;
    assign mon.test_num = test_num_r;
    assign mon.cycles   = cycles_r;
endmodule

// File: tb/tb_test_result_monitor.sv
// Bench for test_result_monitor: a PC-match and a tohost instance share one stimulus stream
// and are compared every cycle against a behavioural model, plus directed literal checks.
`timescale 1ns/1ps
module tb_test_result_monitor;
`ifdef TEST_MONITOR_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_v, we_v;
    logic [31:0] pc_v, gp_v, addr_v, wd_v;
    logic        cmp_en;
    int          checks, errors;

    test_result_monitor_if #(.XLEN(32), .CNT_W(16)) if0 ();
    test_result_monitor_if #(.XLEN(32), .CNT_W(16)) if1 ();

    assign if0.start = start_v;  assign if1.start = start_v;
    assign if0.pc_i  = pc_v;     assign if1.pc_i  = pc_v;
    assign if0.gp_i  = gp_v;     assign if1.gp_i  = gp_v;
    assign if0.mem_we_i    = we_v;   assign if1.mem_we_i    = we_v;
    assign if0.mem_addr_i  = addr_v; assign if1.mem_addr_i  = addr_v;
    assign if0.mem_wdata_i = wd_v;   assign if1.mem_wdata_i = wd_v;

    test_result_monitor #(.XLEN(32), .MODE(0), .PASS_PC(32'h44), .TOHOST_ADDR(32'h1000),
                          .TIMEOUT(30), .CNT_W(16), .STALL_LIMIT(4))
        dut0 (.clk(clk), .rst(rst), .mon(if0));

    test_result_monitor #(.XLEN(32), .MODE(1), .PASS_PC(32'h44), .TOHOST_ADDR(32'h1000),
                          .TIMEOUT(10), .CNT_W(16), .STALL_LIMIT(4))
        dut1 (.clk(clk), .rst(rst), .mon(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: running flag, verdict (0 none, 1 pass, 2 fail, 3 timeout) and counts.
    typedef struct {
        bit          run;
        int          res;
        int unsigned cnt;
        logic [30:0] tnum;
        bit          stl;
        int          scnt;
        logic [31:0] ppc;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mstep(input mdl_t m, input int mode, input int tmo, input int slim,
                                   input logic [31:0] endpc, input logic [31:0] endad);
        mdl_t        n;
        logic [31:0] val;
        bit          ev, sh;
        int          sc;
        n = m;
        if (rst !== 1'b1) begin
            n = '{default: 0};
            return n;
        end
        n.ppc = pc_v;
        if (!m.run) begin
            if (start_v) begin
                n.run = 1; n.res = 0; n.cnt = 0; n.tnum = '0; n.stl = 0; n.scnt = 0;
            end
            return n;
        end
        n.cnt = (m.cnt < 32'hFFFF) ? m.cnt + 1 : m.cnt;
        val   = (mode == 0) ? gp_v : wd_v;
        ev    = (mode == 0) ? (pc_v == endpc) : (we_v && addr_v == endad && wd_v[0]);
        sc    = (pc_v == m.ppc) ? m.scnt + 1 : 0;
        n.scnt = sc;
        sh    = STALL_EN && (sc >= slim);
        if (ev) begin
            n.run = 0;
            if (val == 32'd1) n.res = 1;
            else begin n.res = 2; n.tnum = val[31:1]; end
        end else if (sh) begin
            n.run = 0; n.res = 2; n.tnum = '0; n.stl = 1;
        end else if (n.cnt >= tmo) begin
            n.run = 0; n.res = 3;
        end
        return n;
    endfunction

    function automatic logic [52:0] mvec(input mdl_t m);
        logic [15:0] c;
        c = m.cnt[15:0];
        return {m.run, m.res != 0, m.res == 1, m.res == 2, m.res == 3, m.stl, m.tnum, c};
    endfunction

    always @(posedge clk) begin
        m0 <= mstep(m0, 0, 30, 4, 32'h44, 32'h1000);
        m1 <= mstep(m1, 1, 10, 4, 32'h44, 32'h1000);
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            checks = checks + 2;
            if ({if0.busy, if0.done, if0.pass, if0.fail, if0.timeout, if0.stalled,
                 if0.test_num, if0.cycles} !== mvec(m0)) begin
                errors++;
                $display("FAIL model_dut0 @%0t: got 0x%h want 0x%h", $time,
                         {if0.busy, if0.done, if0.pass, if0.fail, if0.timeout, if0.stalled,
                          if0.test_num, if0.cycles}, mvec(m0));
            end
            if ({if1.busy, if1.done, if1.pass, if1.fail, if1.timeout, if1.stalled,
                 if1.test_num, if1.cycles} !== mvec(m1)) begin
                errors++;
                $display("FAIL model_dut1 @%0t: got 0x%h want 0x%h", $time,
                         {if1.busy, if1.done, if1.pass, if1.fail, if1.timeout, if1.stalled,
                          if1.test_num, if1.cycles}, mvec(m1));
            end
        end
    end

    task automatic lit(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic [31:0] pc, input logic [31:0] gp,
                       input logic we, input logic [31:0] ad, input logic [31:0] wd);
        start_v = s; pc_v = pc; gp_v = gp; we_v = we; addr_v = ad; wd_v = wd;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rpc, rgp, rad, rwd;
    logic        rs, rwe;

    initial begin
        checks = 0; errors = 0; cmp_en = 1'b0;
        rst = 1'b0; start_v = 1'b0; we_v = 1'b0;
        pc_v = 32'h0; gp_v = 32'h0; addr_v = 32'h0; wd_v = 32'h0;

        // Reset state
        cyc(1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        cmp_en = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        lit("rst_busy", if0.busy, 1'b0);
        lit("rst_done", if1.done, 1'b0);
        lit("rst_cycles", if0.cycles, 16'd0);
        rst = 1'b1;

        // PC sweep 0x0..0x44 with gp = 1; the tohost instance times out meanwhile
        cyc(1'b1, 32'h200, 32'h1, 1'b0, 32'h0, 32'h0);
        lit("run_busy0", if0.busy, 1'b1);
        for (int k = 0; k < 18; k++) cyc(1'b0, 32'(k * 4), 32'h1, 1'b0, 32'h0, 32'h0);
        lit("sweep_pass", if0.pass, 1'b1);
        lit("sweep_fail", if0.fail, 1'b0);
        lit("sweep_done", if0.done, 1'b1);
        lit("sweep_cycles", if0.cycles, 16'd18);
        lit("tmo_flag", if1.timeout, 1'b1);
        lit("tmo_cycles", if1.cycles, 16'd10);

        // Events in terminal states are ignored
        for (int k = 0; k < 3; k++) cyc(1'b0, 32'h44, 32'h7, 1'b1, 32'h1000, 32'hB);
        lit("sticky_pass", if0.pass, 1'b1);
        lit("sticky_tnum", if0.test_num, 31'd0);
        lit("sticky_tmo", if1.timeout, 1'b1);

        // Restart: prior pass cleared; gp = 7 fail; tohost 2 ignored, 0xB fail, 1 sticky
        cyc(1'b1, 32'h300, 32'h1, 1'b0, 32'h0, 32'h0);
        lit("restart_pass", if0.pass, 1'b0);
        lit("restart_cycles", if0.cycles, 16'd0);
        cyc(1'b0, 32'h8, 32'h1, 1'b1, 32'h1000, 32'h2);
        lit("even_store_busy", if1.busy, 1'b1);
        cyc(1'b0, 32'hC, 32'h1, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 32'h10, 32'h1, 1'b1, 32'h1000, 32'hB);
        lit("tohost_fail", if1.fail, 1'b1);
        lit("tohost_tnum", if1.test_num, 31'd5);
        cyc(1'b0, 32'h44, 32'h7, 1'b1, 32'h1000, 32'h1);
        lit("gp_fail", if0.fail, 1'b1);
        lit("gp_tnum", if0.test_num, 31'd3);
        lit("gp_pass", if0.pass, 1'b0);
        lit("tohost_sticky_pass", if1.pass, 1'b0);
        lit("tohost_sticky_tnum", if1.test_num, 31'd5);
        cyc(1'b0, 32'h50, 32'h1, 1'b0, 32'h0, 32'h0);

        // Completion on the timeout cycle: completion wins
        cyc(1'b1, 32'h400, 32'h1, 1'b0, 32'h0, 32'h0);
        for (int i = 1; i <= 30; i++)
            cyc(1'b0, (i == 30) ? 32'h44 : 32'(32'h100 + i * 4), 32'h1, i == 10, 32'h1000, 32'h1);
        lit("coinc_pass1", if1.pass, 1'b1);
        lit("coinc_tmo1", if1.timeout, 1'b0);
        lit("coinc_cyc1", if1.cycles, 16'd10);
        lit("coinc_pass0", if0.pass, 1'b1);
        lit("coinc_cyc0", if0.cycles, 16'd30);

        // Reset in the middle of a run
        cyc(1'b1, 32'h500, 32'h1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'(32'h600 + i * 4), 32'h1, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        cyc(1'b0, 32'h700, 32'h1, 1'b0, 32'h0, 32'h0);
        lit("midrst_all0", {if0.busy, if0.done, if0.pass, if0.fail, if0.timeout, if0.cycles}, 64'd0);
        lit("midrst_all1", {if1.busy, if1.done, if1.test_num, if1.cycles}, 64'd0);
        rst = 1'b1;

        // PC held at 0x20 for the whole run
        cyc(1'b0, 32'h20, 32'h1, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 32'h20, 32'h1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 35; i++) cyc(1'b0, 32'h20, 32'h1, 1'b0, 32'h0, 32'h0);
        if (STALL_EN) begin
            lit("stall_fail", if0.fail, 1'b1);
            lit("stall_flag", if0.stalled, 1'b1);
            lit("stall_tnum", if0.test_num, 31'd0);
            lit("stall_cycles", if0.cycles, 16'd4);
        end else begin
            lit("nostall_tmo", if0.timeout, 1'b1);
            lit("nostall_flag", if0.stalled, 1'b0);
            lit("nostall_cycles", if0.cycles, 16'd30);
        end

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) != 0);
            rs  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 15))
                0:             rpc = 32'h44;
                1, 2, 3, 4, 5: rpc = pc_v;
                default:       rpc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            case ($urandom_range(0, 3))
                0:       rgp = 32'h1;
                1:       rgp = 32'h7;
                2:       rgp = 32'h2A;
                default: rgp = $urandom;
            endcase
            rwe = $urandom_range(0, 1) == 1;
            rad = ($urandom_range(0, 1) == 1) ? 32'h1000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rwd = 32'h1;
                1:       rwd = 32'h2;
                2:       rwd = 32'hB;
                default: rwd = $urandom;
            endcase
            cyc(rs, rpc, rgp, rwe, rad, rwd);
        end
        rst = 1'b1;
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

        @(posedge clk);
        #2;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/test_result_monitor.md
Name: test_result_monitor

Overview:
- Synthesizable pass/fail detector for riscv-tests runs on the core; replaces bench-side PC/gp polling with a parametrised, reusable monitor.
- Two detection modes:
  - PC-match with gp (x3) check.
  - tohost-store decode.
- Includes a cycle watchdog and sticky result flags.
- Instantiated beside Core; outputs are readable by the bench or by an FPGA LED/UART wrapper.

Parameters:
- XLEN, 32, data/address width.
- MODE, 0, 0 = PC-match mode, 1 = tohost-store mode.
- PASS_PC, 32'h44, PC value that signals test end (MODE 0).
- TOHOST_ADDR, 32'h1000, store address that signals test end (MODE 1).
- TIMEOUT, 5000, RUN cycles before timeout is declared; must be ≥ 1.
- CNT_W, 16, cycle counter width; must hold TIMEOUT.
- STALL_LIMIT, 64, consecutive equal-PC cycles counted as a hang (optional feature only).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  arm pulse; begins a run.
- pc_i  in  XLEN  core PC of the current cycle.
- gp_i  in  XLEN  core register x3 (gp).
- mem_we_i  in  1  core data-store strobe.
- mem_addr_i  in  XLEN  store address.
- mem_wdata_i  in  XLEN  store data.
- busy  out  1  state == RUN.
- done  out  1  terminal state reached (PASS, FAIL or TIMEOUT).
- pass  out  1  test passed.
- fail  out  1  test failed (includes stall).
- timeout  out  1  watchdog expired.
- stalled  out  1  fail caused by stall detection.
- test_num  out  XLEN-1  failing test number.
- cycles  out  CNT_W  RUN cycles elapsed, frozen at end.

Behaviour:
- Reset (rst == 0 at posedge):
  - State goes to IDLE.
  - All outputs and counters are 0.
  - Reset wins over every other input, including in the middle of a run.
- States: IDLE, RUN, PASS, FAIL, TMO. PASS, FAIL and TMO are sticky.
- start == 1 in IDLE/PASS/FAIL/TMO:
  - Next state RUN.
  - cycles = 0; pass/fail/timeout/stalled/test_num cleared.
  - start during RUN is ignored.
- RUN, every cycle: cycles increments by 1.
- Completion event, evaluated only in RUN:
  - MODE 0: event when pc_i == PASS_PC. gp_i == 1 → PASS; otherwise → FAIL with test_num = gp_i[XLEN-1:1].
  - MODE 1: event when mem_we_i && mem_addr_i == TOHOST_ADDR && mem_wdata_i[0] == 1. mem_wdata_i == 1 → PASS; otherwise → FAIL with test_num = mem_wdata_i[XLEN-1:1].
  - MODE 1: a tohost store with wdata[0] == 0 is ignored and the run continues.
- Timeout: when cycles == TIMEOUT-1 in RUN with no completion event that cycle → TMO.
- Simultaneous completion and timeout: completion wins.
- Latency: flags and done are registered and assert on the posedge after the event cycle.
- cycles holds its value in terminal states and equals the count including the event cycle.
- Events outside RUN (IDLE or terminal states) are ignored and never change the flags.
- Counter saturates at all-ones; it never wraps.
- Exactly one of pass/fail/timeout is 1 whenever done is 1.

Optional Feature:
- Macro: TEST_MONITOR_STALL_EN.
- Defined:
  - Stall counter tracks consecutive RUN cycles where pc_i equals its previous-cycle value. It resets on any PC change and on entry to RUN.
  - On reaching STALL_LIMIT → FAIL with stalled = 1 and test_num = 0.
  - Priority: completion > stall > timeout.
- Undefined: no stall logic; stalled is tied to 0; STALL_LIMIT is unused.

Test Plan:
- MODE 0, PASS_PC = 32'h44. Reset, then start. Drive pc_i through 0,4,…; at 0x44 hold gp_i = 1 → next cycle pass = 1, done = 1, fail = 0; cycles = 18 for a 0x0–0x44 sweep at one PC per cycle.
- MODE 0: pc_i = 0x44 with gp_i = 32'h7 → fail = 1, test_num = 3, pass = 0.
- MODE 1, TOHOST_ADDR = 32'h1000:
  - Store wdata = 2 → ignored, busy stays 1.
  - Then store wdata = 32'h0000000B → fail = 1, test_num = 5.
  - Then a later store with wdata = 1 → flags unchanged (sticky).
- TIMEOUT = 10, no event → timeout = 1 on the 10th posedge after RUN entry, cycles = 10.
- Event on the same cycle as the timeout → pass only.
- rst = 0 mid-RUN → all outputs 0 next cycle.
- After a new start: pass from the prior run is cleared and the run completes normally.
- TEST_MONITOR_STALL_EN, STALL_LIMIT = 4: pc_i held constant at 0x20 → fail = 1, stalled = 1 after 4 cycles.
- Same stimulus without the macro → stalled = 0 and the run ends in timeout.
